// File: rtl/rd_data2b.sv
// Block reader: fetches four consecutive 32-bit words from data memory and
// packs them into one 128-bit AES block (lowest address -> most significant word).
module rd_data2b #(
  parameter logic [31:0] BASE_ADDR   = 32'd400,
  parameter int unsigned MEM_LATENCY = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [31:0]  rd_data,
  output logic         en_r_datamem,
  output logic [31:0]  addr_rd,
  output logic [127:0] block_out,
  output logic         block_valid,
  output logic         busy
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  localparam logic [2:0] LAT = 3'(MEM_LATENCY);

  state_t         state_q;
  logic [1:0]     idx_q;
  logic [2:0]     lat_cnt_q;
  logic [127:0]   shadow_q;
  logic [127:0]   shadow_d;
  logic [1:0]     idx_d;
  logic [31:0]    addr_d;
  logic           en_q;
  logic [31:0]    addr_q;
  logic [127:0]   block_q;
  logic           valid_q;
  logic           busy_q;

  always_comb begin
    shadow_d = shadow_q;
    for (int unsigned i = 0; i < 4; i++) begin
      if (idx_q == 2'(i)) shadow_d[127-32*i -: 32] = rd_data;
    end
    idx_d  = idx_q + 2'd1;
    addr_d = BASE_ADDR + {28'd0, idx_d, 2'b00};
  end

  // Outputs are registered on the transition into each state, so the word
  // being captured in the last WAIT cycle is folded straight into block_out.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      lat_cnt_q <= '0;
      shadow_q  <= '0;
      en_q      <= 1'b0;
      addr_q    <= '0;
      block_q   <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          valid_q <= 1'b0;
          if (start) begin
            state_q <= REQ;
            idx_q   <= '0;
            en_q    <= 1'b1;
            addr_q  <= BASE_ADDR;
            busy_q  <= 1'b1;
          end
        end
        REQ: begin
          state_q   <= WAIT;
          lat_cnt_q <= 3'd1;
          en_q      <= 1'b0;
          addr_q    <= '0;
        end
        WAIT: begin
          if (lat_cnt_q < LAT) begin
            lat_cnt_q <= lat_cnt_q + 3'd1;
          end else begin
            shadow_q <= shadow_d;
            if (idx_q == 2'd3) begin
              state_q <= DONE;
              block_q <= shadow_d;
              valid_q <= 1'b1;
            end else begin
              idx_q   <= idx_d;
              state_q <= REQ;
              en_q    <= 1'b1;
              addr_q  <= addr_d;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign en_r_datamem = en_q;
  assign addr_rd      = addr_q;
  assign block_out    = block_q;
  assign block_valid  = valid_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_rd_data2b.sv
// Directed bench for rd_data2b: three instances (L=1, L=3, wrapping base)
// fed by a latency-aware memory model that returns junk outside capture cycles.
module tb_rd_data2b;

  localparam int          LATP  [3] = '{1, 3, 1};
  localparam logic [31:0] BASEP [3] = '{32'd400, 32'd400, 32'hFFFF_FFF8};
  localparam logic [127:0] BLK_A = 128'h00112233_44556677_8899AABB_CCDDEEFF;
  localparam logic [127:0] BLK_B = 128'h10203040_50607080_90A0B0C0_D0E0F000;

  logic         clk;
  logic         rst_w   [3];
  logic         start_w [3];
  logic [31:0]  rd_w    [3];
  logic         en_w    [3];
  logic [31:0]  addr_w  [3];
  logic [127:0] blk_w   [3];
  logic         valid_w [3];
  logic         busy_w  [3];

  logic [31:0]  mem_words [4];
  logic         en_h [3][5];
  logic [31:0]  ad_h [3][5];

  int nvec = 0;
  int nerr = 0;

  int           rq_cyc [$];
  logic [31:0]  rq_addr[$];
  int           vd_cyc [$];
  logic [127:0] vd_blk [$];
  logic [63:0]  busy_b;

  rd_data2b #(.BASE_ADDR(32'd400), .MEM_LATENCY(1)) u_l1 (
    .clk(clk), .reset(rst_w[0]), .start(start_w[0]), .rd_data(rd_w[0]),
    .en_r_datamem(en_w[0]), .addr_rd(addr_w[0]), .block_out(blk_w[0]),
    .block_valid(valid_w[0]), .busy(busy_w[0]));

  rd_data2b #(.BASE_ADDR(32'd400), .MEM_LATENCY(3)) u_l3 (
    .clk(clk), .reset(rst_w[1]), .start(start_w[1]), .rd_data(rd_w[1]),
    .en_r_datamem(en_w[1]), .addr_rd(addr_w[1]), .block_out(blk_w[1]),
    .block_valid(valid_w[1]), .busy(busy_w[1]));

  rd_data2b #(.BASE_ADDR(32'hFFFF_FFF8), .MEM_LATENCY(1)) u_wrap (
    .clk(clk), .reset(rst_w[2]), .start(start_w[2]), .rd_data(rd_w[2]),
    .en_r_datamem(en_w[2]), .addr_rd(addr_w[2]), .block_out(blk_w[2]),
    .block_valid(valid_w[2]), .busy(busy_w[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory: data for a request made in cycle c appears in cycle c+L only.
  always @(negedge clk) begin
    for (int j = 0; j < 3; j++) begin
      logic [31:0] off;
      for (int k = 4; k > 0; k--) begin
        en_h[j][k] = en_h[j][k-1];
        ad_h[j][k] = ad_h[j][k-1];
      end
      en_h[j][0] = en_w[j];
      ad_h[j][0] = addr_w[j];
      off = ad_h[j][LATP[j]] - BASEP[j];
      if (en_h[j][LATP[j]] === 1'b1) rd_w[j] = mem_words[off[3:2]];
      else rd_w[j] = 32'hDEADBEEF;
    end
  end

  task automatic load_mem(input logic [127:0] b);
    for (int i = 0; i < 4; i++) mem_words[i] = b[127-32*i -: 32];
  endtask

  // Entered just after a rising edge; that cycle is cycle 0 with start = 1.
  task automatic run(input int s, input int ncyc, input int hold_last,
                     input int p1, input int p2, input int chg);
    rq_cyc.delete(); rq_addr.delete(); vd_cyc.delete(); vd_blk.delete();
    busy_b = '0;
    start_w[s] = 1'b1;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      if (en_w[s] === 1'b1) begin rq_cyc.push_back(c); rq_addr.push_back(addr_w[s]); end
      if (valid_w[s] === 1'b1) begin vd_cyc.push_back(c); vd_blk.push_back(blk_w[s]); end
      busy_b[c] = busy_w[s];
      @(posedge clk); #1;
      start_w[s] = (c + 1 <= hold_last) || (c + 1 == p1) || (c + 1 == p2);
      if (c + 1 == chg) load_mem(BLK_B);
    end
    start_w[s] = 1'b0;
  endtask

  task automatic test_reset;
    #2;
    for (int j = 0; j < 3; j++) begin
      nvec++;
      if ({en_w[j], addr_w[j], blk_w[j], valid_w[j], busy_w[j]} !== '0) begin
        nerr++;
        $display("FAIL reset_outputs dut%0d: en=%b addr=%h blk=%h valid=%b busy=%b, required all 0",
                 j, en_w[j], addr_w[j], blk_w[j], valid_w[j], busy_w[j]);
      end
    end
    @(posedge clk); #1;
    for (int j = 0; j < 3; j++) rst_w[j] = 1'b1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_l1;
    logic [31:0] ea [4] = '{32'd400, 32'd404, 32'd408, 32'd412};
    int          ec [4] = '{1, 3, 5, 7};
    run(0, 12, 0, -1, -1, -1);
    nvec++;
    if (rq_cyc.size() != 4) begin nerr++; $display("FAIL l1_req_count got %0d required 4", rq_cyc.size()); end
    for (int i = 0; i < 4; i++) begin
      nvec++;
      if (rq_cyc[i] != ec[i] || rq_addr[i] !== ea[i]) begin
        nerr++;
        $display("FAIL l1_req%0d got cycle %0d addr %h required cycle %0d addr %h", i, rq_cyc[i], rq_addr[i], ec[i], ea[i]);
      end
    end
    nvec++;
    if (vd_cyc.size() != 1 || vd_cyc[0] != 9) begin
      nerr++; $display("FAIL l1_valid got %0d pulses first at %0d required 1 at 9", vd_cyc.size(), vd_cyc[0]);
    end
    nvec++;
    if (vd_blk[0] !== BLK_A) begin nerr++; $display("FAIL l1_block got %h required %h", vd_blk[0], BLK_A); end
    nvec++;
    if (busy_b[10:0] !== 11'h3FE) begin nerr++; $display("FAIL l1_busy got %h required 3fe", busy_b[10:0]); end
    nvec++;
    if (blk_w[0] !== BLK_A) begin nerr++; $display("FAIL l1_block_hold got %h required %h", blk_w[0], BLK_A); end
  endtask

  task automatic test_l3;
    int ec [4] = '{1, 5, 9, 13};
    run(1, 20, 0, -1, -1, -1);
    nvec++;
    if (rq_cyc.size() != 4) begin nerr++; $display("FAIL l3_req_count got %0d required 4", rq_cyc.size()); end
    for (int i = 0; i < 4; i++) begin
      nvec++;
      if (rq_cyc[i] != ec[i]) begin nerr++; $display("FAIL l3_req%0d got cycle %0d required %0d", i, rq_cyc[i], ec[i]); end
    end
    nvec++;
    if (vd_cyc.size() != 1 || vd_cyc[0] != 17) begin
      nerr++; $display("FAIL l3_valid got %0d pulses first at %0d required 1 at 17", vd_cyc.size(), vd_cyc[0]);
    end
    nvec++;
    if (vd_blk[0] !== BLK_A) begin nerr++; $display("FAIL l3_block got %h required %h", vd_blk[0], BLK_A); end
    nvec++;
    if (busy_b[18:0] !== 19'h3FFFE) begin nerr++; $display("FAIL l3_busy got %h required 3fffe", busy_b[18:0]); end
  endtask

  task automatic test_back_to_back;
    run(0, 22, 19, -1, -1, 10);
    nvec++;
    if (vd_cyc.size() != 2 || vd_cyc[0] != 9 || vd_cyc[1] != 19) begin
      nerr++; $display("FAIL b2b_valid got %0d pulses at %0d,%0d required 2 at 9,19", vd_cyc.size(), vd_cyc[0], vd_cyc[1]);
    end
    nvec++;
    if (rq_cyc.size() != 8 || rq_cyc[4] != 11) begin
      nerr++; $display("FAIL b2b_requests got %0d second-read start %0d required 8 and 11", rq_cyc.size(), rq_cyc[4]);
    end
    nvec++;
    if (vd_blk[0] !== BLK_A) begin nerr++; $display("FAIL b2b_block0 got %h required %h", vd_blk[0], BLK_A); end
    nvec++;
    if (vd_blk[1] !== BLK_B) begin nerr++; $display("FAIL b2b_block1 got %h required %h", vd_blk[1], BLK_B); end
    load_mem(BLK_A);
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic test_start_while_busy;
    run(0, 14, 0, 3, 6, -1);
    nvec++;
    if (vd_cyc.size() != 1 || vd_cyc[0] != 9) begin
      nerr++; $display("FAIL busy_start_valid got %0d pulses first at %0d required 1 at 9", vd_cyc.size(), vd_cyc[0]);
    end
    nvec++;
    if (rq_cyc.size() != 4) begin nerr++; $display("FAIL busy_start_requests got %0d required 4", rq_cyc.size()); end
  endtask

  task automatic test_reset_mid;
    int nv, nr;
    run(0, 12, 0, -1, -1, 2);
    start_w[0] = 1'b1;
    @(posedge clk); #1;
    start_w[0] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_w[0] = 1'b0;
    #1;
    nvec++;
    if ({en_w[0], addr_w[0], blk_w[0], valid_w[0], busy_w[0]} !== '0) begin
      nerr++;
      $display("FAIL midreset_outputs en=%b addr=%h blk=%h valid=%b busy=%b required all 0",
               en_w[0], addr_w[0], blk_w[0], valid_w[0], busy_w[0]);
    end
    load_mem(BLK_A);
    repeat (2) @(posedge clk);
    #1;
    rst_w[0] = 1'b1;
    nv = 0; nr = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (valid_w[0] === 1'b1) nv++;
      if (en_w[0] === 1'b1) nr++;
    end
    nvec++;
    if (nv != 0 || nr != 0) begin nerr++; $display("FAIL midreset_quiet got valid=%0d req=%0d required 0,0", nv, nr); end
    @(posedge clk); #1;
    run(0, 12, 0, -1, -1, -1);
    nvec++;
    if (vd_cyc.size() != 1 || vd_cyc[0] != 9 || vd_blk[0] !== BLK_A) begin
      nerr++; $display("FAIL midreset_restart got %0d pulses at %0d blk %h required 1 at 9 blk %h",
                       vd_cyc.size(), vd_cyc[0], vd_blk[0], BLK_A);
    end
  endtask

  task automatic test_wrap;
    logic [31:0] ea [4] = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};
    run(2, 12, 0, -1, -1, -1);
    for (int i = 0; i < 4; i++) begin
      nvec++;
      if (rq_addr[i] !== ea[i]) begin nerr++; $display("FAIL wrap_addr%0d got %h required %h", i, rq_addr[i], ea[i]); end
    end
    nvec++;
    if (vd_blk[0] !== BLK_A) begin nerr++; $display("FAIL wrap_block got %h required %h", vd_blk[0], BLK_A); end
  endtask

  initial begin
    for (int j = 0; j < 3; j++) begin
      rst_w[j] = 1'b0;
      start_w[j] = 1'b0;
      rd_w[j] = '0;
      for (int k = 0; k < 5; k++) begin en_h[j][k] = 1'b0; ad_h[j][k] = '0; end
    end
    load_mem(BLK_A);
    test_reset;
    test_l1;
    test_l3;
    test_back_to_back;
    test_start_while_busy;
    test_reset_mid;
    test_wrap;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/rd_data2b.md
# rd_data2b

Data-memory-to-block reader for the RV32 AES path. On a start request it fetches four consecutive 32-bit words from data memory and assembles them into one 128-bit block for the AES core. It then presents the block with a one-cycle valid pulse. It is the read-side counterpart of the AES result write-back unit and uses the same word ordering: lowest address maps to the most significant word.

## Interface
- BASE_ADDR, 32'd400: byte address of word 0; words are read at BASE_ADDR + 4*i, i = 0..3.
- MEM_LATENCY, 1: cycles from the read-request cycle to the cycle in which rd_data is valid. Legal range 1..4.
- clk  input  1  single clock; all logic on rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  begin a block read; sampled only in IDLE.
- rd_data  input  32  read data from data memory.
- en_r_datamem  output  1  read request strobe to data memory.
- addr_rd  output  32  read byte address, meaningful only while en_r_datamem = 1.
- block_out  output  128  assembled block; word i occupies bits [127-32*i -: 32].
- block_valid  output  1  one-cycle pulse; block_out is new and stable.
- busy  output  1  high from the first request cycle through the DONE cycle.

## Operation
- States: IDLE, REQ, WAIT, DONE. Internal state: 2-bit word index idx, 3-bit latency counter lat_cnt, 128-bit shadow register.
- IDLE
  - start = 1 → REQ with idx = 0.
  - start = 0 → stay in IDLE.
- REQ (one cycle)
  - Drives en_r_datamem = 1 and addr_rd = BASE_ADDR + {idx, 2'b00}.
  - Then goes to WAIT with lat_cnt = 1.
- WAIT
  - If lat_cnt < MEM_LATENCY: increment lat_cnt and stay in WAIT.
  - If lat_cnt == MEM_LATENCY: capture rd_data into shadow word idx.
  - After the capture: if idx == 3, go to DONE; otherwise idx += 1 and go to REQ.
- DONE (one cycle)
  - block_out <= shadow; block_valid = 1.
  - Then IDLE.
- Output gating:
  - en_r_datamem = 1 only in REQ.
  - addr_rd = 0 outside REQ.
  - busy = 1 in REQ, WAIT and DONE.
- start while busy is ignored and is not queued.
- If start is still high in the IDLE cycle after DONE, a new read begins; back-to-back blocks are legal.
- block_out changes only in DONE. It holds its last value across IDLE and during the next read.
- Address arithmetic is 32-bit unsigned and wraps modulo 2^32; there is no alignment check on BASE_ADDR.
- Each word gets exactly one request strobe; there are no retries.

## Timing
- Reset (asynchronous, any state, including mid-read):
  - state = IDLE, idx = 0, lat_cnt = 0, shadow = 0.
  - en_r_datamem = 0, addr_rd = 0, block_out = 0, block_valid = 0, busy = 0.
  - A partially read block is discarded and block_valid is not asserted.
- Cycle 0 is the IDLE cycle in which start = 1 is sampled. Let L = MEM_LATENCY.
- Request for word i is in cycle 1 + i*(L+1).
- Capture of word i is at the end of cycle 1 + i*(L+1) + L, using rd_data valid in that cycle.
- block_valid is in cycle 4L + 5. For L = 1 that is cycle 9; for L = 3 it is cycle 17.
- busy rises in cycle 1 and falls after cycle 4L + 5.
- Minimum start-to-start spacing is 4L + 6 cycles.
- rd_data is ignored in every cycle except capture cycles.

## Test plan
- Reset, L = 1, BASE_ADDR = 400:
  - Stimulus: memory at 400/404/408/412 holds 0x00112233 / 0x44556677 / 0x8899AABB / 0xCCDDEEFF; pulse start.
  - Response: requests at cycles 1,3,5,7 with addr 400,404,408,412; block_valid only at cycle 9; block_out = 0x00112233_44556677_8899AABB_CCDDEEFF.
- L = 3, same memory contents:
  - Requests at cycles 1,5,9,13; block_valid at cycle 17.
  - Driving rd_data = 0xDEADBEEF in every non-capture cycle does not change block_out.
- start held high continuously, L = 1:
  - Two reads back-to-back, block_valid at cycles 9 and 19.
  - The memory contents change between the two reads, and the second block_out reflects the new data.
- start pulsed at cycles 3 and 6 during a read:
  - Ignored; exactly one block_valid at cycle 9 and no extra requests.
- reset asserted at cycle 4 of a read, released at cycle 6, L = 1:
  - All outputs are 0 immediately on assertion and block_out = 0; no block_valid.
  - A new start completes normally.
- BASE_ADDR = 32'hFFFF_FFF8:
  - Request addresses are FFFF_FFF8, FFFF_FFFC, 0000_0000, 0000_0004, wrapping.
